hazard_sequencer: RTL and testbench

//  Pipeline sequencer for the 5-stage RISC-V core. Detects load-use hazards, flushes
//  IF/ID on taken branches resolved in ID, and freezes the pipeline while the

---
 rtl/hazard_sequencer.sv | 116 +++++++++++
 tb/tb_hazard_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: load-use stall, branch flush, memory-wait freeze
// with a timeout watchdog and a saturating stall-cycle counter.
module hazard_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ID_rs1_i,
   input  logic [4:0]       ID_rs2_i,
   input  logic [4:0]       EX_rd_i,
   input  logic             EX_MemRead_i,
   input  logic             ID_Branch_i,
   input  logic             ID_BranchTaken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             PCWrite_o,
   output logic             IFID_Write_o,
   output logic             IFID_Flush_o,
   output logic             NoOp_o,
   output logic             IDEX_Write_o,
   output logic             EXMEM_Write_o,
   output logic             MEMWB_Bubble_o,
   output logic             fault_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      FAULT
   } state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic          memfrz;
   logic          lu;
   logic          br;

   assign memfrz = mem_req_i & ~mem_ack_i;
   assign lu     = EX_MemRead_i & (EX_rd_i != 5'd0) &
                   ((EX_rd_i == ID_rs1_i) | (EX_rd_i == ID_rs2_i));
   assign br     = ID_Branch_i & ID_BranchTaken_i;

   always_comb begin
      PCWrite_o      = 1'b1;
      IFID_Write_o   = 1'b1;
      IFID_Flush_o   = 1'b0;
      NoOp_o         = 1'b0;
      IDEX_Write_o   = 1'b1;
      EXMEM_Write_o  = 1'b1;
      MEMWB_Bubble_o = 1'b0;
      if (rst_i) begin
         PCWrite_o      = 1'b0;
         IFID_Write_o   = 1'b0;
         NoOp_o         = 1'b1;
         IDEX_Write_o   = 1'b0;
         EXMEM_Write_o  = 1'b0;
         MEMWB_Bubble_o = 1'b1;
      end else if (state == FAULT || memfrz) begin
         PCWrite_o      = 1'b0;
         IFID_Write_o   = 1'b0;
         IDEX_Write_o   = 1'b0;
         EXMEM_Write_o  = 1'b0;
         MEMWB_Bubble_o = 1'b1;
      end else if (lu) begin
         // a branch waiting behind the load is re-evaluated next cycle
         PCWrite_o    = 1'b0;
         IFID_Write_o = 1'b0;
         NoOp_o       = 1'b1;
      end else if (br) begin
         IFID_Flush_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= RUN;
         wait_cnt    <= '0;
         fault_o     <= 1'b0;
         stall_cnt_o <= '0;
      end else begin
         case (state)
            RUN: begin
               if (memfrz) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WW'(1);
               end
            end
            MEM_WAIT: begin
               if (!memfrz) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
                  state   <= FAULT;
                  fault_o <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            FAULT: begin
               fault_o <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
         if (!PCWrite_o && !(&stall_cnt_o))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: two instances (default and
// CNT_W=4/MEM_TIMEOUT=32) share stimulus and are checked against a model.
module tb_hazard_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       mr, bb, bt, req, ack;

   logic [1:0]       pcw, ifw, flu, nop, idw, exw, bub, flt;
   logic [31:0]      st0;
   logic [3:0]       st1;

   always #5 clk = ~clk;

   hazard_sequencer u0 (
      .clk_i(clk), .rst_i(rst),
      .ID_rs1_i(rs1), .ID_rs2_i(rs2), .EX_rd_i(rd),
      .EX_MemRead_i(mr), .ID_Branch_i(bb), .ID_BranchTaken_i(bt),
      .mem_req_i(req), .mem_ack_i(ack),
      .PCWrite_o(pcw[0]), .IFID_Write_o(ifw[0]), .IFID_Flush_o(flu[0]),
      .NoOp_o(nop[0]), .IDEX_Write_o(idw[0]), .EXMEM_Write_o(exw[0]),
      .MEMWB_Bubble_o(bub[0]), .fault_o(flt[0]), .stall_cnt_o(st0)
   );

   hazard_sequencer #(.MEM_TIMEOUT(32), .CNT_W(4)) u1 (
      .clk_i(clk), .rst_i(rst),
      .ID_rs1_i(rs1), .ID_rs2_i(rs2), .EX_rd_i(rd),
      .EX_MemRead_i(mr), .ID_Branch_i(bb), .ID_BranchTaken_i(bt),
      .mem_req_i(req), .mem_ack_i(ack),
      .PCWrite_o(pcw[1]), .IFID_Write_o(ifw[1]), .IFID_Flush_o(flu[1]),
      .NoOp_o(nop[1]), .IDEX_Write_o(idw[1]), .EXMEM_Write_o(exw[1]),
      .MEMWB_Bubble_o(bub[1]), .fault_o(flt[1]), .stall_cnt_o(st1)
   );

   // {PCWrite, IFID_Write, Flush, NoOp, IDEX_Write, EXMEM_Write, Bubble}
   typedef struct packed {
      logic             known;
      logic [1:0][6:0]  comb;
      logic [1:0]       fault;
      logic [1:0][31:0] stall;
      logic [31:0]      cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   bit     m_known;
   bit     m_fault[2];
   bit     m_wait[2];
   int     m_waited[2];
   longint m_stall[2];
   int     tmo[2] = '{16, 32};
   longint cap[2] = '{64'hFFFF_FFFF, 64'd15};

   task automatic chk(input string name, input int inst,
                      input logic [31:0] act, input logic [31:0] exp,
                      input logic [31:0] c);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s u%0d cycle %0d: got %0h expected %0h",
                  name, inst, c, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic m, input logic br_i,
                       input logic tk, input logic rq, input logic ak);
      exp_t e;
      bit   frz, lu, brt;
      @(posedge clk);
      #1;
      rst = r; rs1 = a; rs2 = b; rd = d;
      mr = m; bb = br_i; bt = tk; req = rq; ack = ak;
      cyc++;
      frz = rq && !ak;
      lu  = m && d != 0 && (d == a || d == b);
      brt = br_i && tk;
      e.known = m_known;
      e.cyc   = cyc;
      for (int i = 0; i < 2; i++) begin
         if (r)                     e.comb[i] = 7'b0001001;
         else if (m_fault[i] || frz) e.comb[i] = 7'b0000001;
         else if (lu)               e.comb[i] = 7'b0001110;
         else if (brt)              e.comb[i] = 7'b1110110;
         else                       e.comb[i] = 7'b1100110;
         e.fault[i] = m_fault[i];
         e.stall[i] = 32'(m_stall[i]);
         if (r) begin
            m_fault[i]  = 0;
            m_wait[i]   = 0;
            m_waited[i] = 0;
            m_stall[i]  = 0;
         end else begin
            if (!e.comb[i][6] && m_stall[i] < cap[i]) m_stall[i]++;
            if (m_fault[i]) begin
            end else if (!m_wait[i]) begin
               if (frz) begin
                  m_wait[i]   = 1;
                  m_waited[i] = 1;
               end
            end else if (!frz) begin
               m_wait[i]   = 0;
               m_waited[i] = 0;
            end else if (m_waited[i] == tmo[i]) begin
               m_fault[i] = 1;
            end else begin
               m_waited[i]++;
            end
         end
      end
      if (r) m_known = 1;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      logic [1:0][6:0] ac;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ac[0] = {pcw[0], ifw[0], flu[0], nop[0], idw[0], exw[0], bub[0]};
            ac[1] = {pcw[1], ifw[1], flu[1], nop[1], idw[1], exw[1], bub[1]};
            for (int i = 0; i < 2; i++) begin
               chk("ctrl", i, 32'(ac[i]), 32'(e.comb[i]), e.cyc);
               if (e.known) chk("fault", i, 32'(flt[i]), 32'(e.fault[i]), e.cyc);
            end
            if (e.known) begin
               chk("stall_cnt", 0, st0, e.stall[0], e.cyc);
               chk("stall_cnt", 1, {28'd0, st1}, e.stall[1], e.cyc);
            end
         end
      end
   end

   initial begin
      bit  pend;
      int  hold;
      bit  r, q, k;
      rst = 1; rs1 = 0; rs2 = 0; rd = 0;
      mr = 0; bb = 0; bt = 0; req = 0; ack = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // load-use on rs2, then cleared
      step(0, 1, 5, 5, 1, 0, 0, 0, 0);
      step(0, 1, 5, 5, 0, 0, 0, 0, 0);
      // rd = x0 never stalls
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      // memory wait of 3 cycles then ack
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // zero-cycle access
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      // branch with load-use, then branch alone
      step(0, 3, 4, 3, 1, 1, 1, 0, 0);
      step(0, 3, 4, 3, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // ack never: u0 faults, u1 counter saturates
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (24) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (4) step(0, 0, 0, 0, 0, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 0, 0);
      pend = 0;
      hold = 0;
      for (int n = 0; n < 1500; n++) begin
         r = ($urandom_range(99) == 0);
         if (hold == 0 && $urandom_range(149) == 0) hold = 40;
         q = pend ? 1'b1 : ($urandom_range(2) == 0);
         k = (hold > 0) ? 1'b0 : ($urandom_range(3) == 0);
         if (hold > 0) hold--;
         step(r, 5'($urandom_range(3)), 5'($urandom_range(3)),
              5'($urandom_range(3)), 1'($urandom), 1'($urandom),
              1'($urandom), q, k);
         pend = !r && q && !k;
      end
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
